// File: rtl/mole_field.sv
// Whack-a-mole game core: pops one mole at a time at pseudo-random holes,
// scores beam hits while firing, and counts down the game clock in BCD.
module mole_field #(
  parameter int SEC_CYCLES = 100_000_000,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int UP_CYCLES  = 75_000_000,
  parameter int GAME_SECS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        shooting,
  input  logic [3:0]  hit_sensor,
  output logic [3:0]  mole,
  output logic        hit,
  output logic        miss,
  output logic [15:0] score_bcd,
  output logic [7:0]  time_bcd,
  output logic        game_over
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int UW = (UP_CYCLES  > 1) ? $clog2(UP_CYCLES)  : 1;

  localparam logic [3:0]  SEC_TENS  = 4'(GAME_SECS / 10);
  localparam logic [3:0]  SEC_ONES  = 4'(GAME_SECS % 10);
  localparam logic [7:0]  TIME_INIT = {SEC_TENS, SEC_ONES};
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [1:0]    state;
  logic [SW-1:0] sec_cnt;
  logic [GW-1:0] gap_cnt;
  logic [UW-1:0] up_cnt;
  logic [15:0]   lfsr;
  logic [1:0]    prev;

  logic          lfsr_fb, in_play, gap_done, up_done, sec_tick, final_tick, hit_now;
  logic [1:0]    idx_next;
  logic [7:0]    time_next;

  // Per-digit BCD increment, saturating at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    in_play    = (state == ST_GAP) || (state == ST_UP);
    gap_done   = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
    up_done    = (state == ST_UP)  && (up_cnt  == UW'(UP_CYCLES - 1));
    sec_tick   = in_play && (sec_cnt == SW'(SEC_CYCLES - 1));
    hit_now    = (state == ST_UP) && shooting && hit_sensor[prev];
    // never repeat the previous hole
    idx_next   = (lfsr[1:0] == prev) ? prev + 2'd1 : lfsr[1:0];
    time_next  = (time_bcd[3:0] == 4'd0) ? {time_bcd[7:4] - 4'd1, 4'd9}
                                         : {time_bcd[7:4], time_bcd[3:0] - 4'd1};
    final_tick = sec_tick && (time_next == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sec_cnt   <= '0;
      gap_cnt   <= '0;
      up_cnt    <= '0;
      lfsr      <= LFSR_SEED;
      prev      <= 2'd0;
      mole      <= 4'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      score_bcd <= 16'h0000;
      time_bcd  <= TIME_INIT;
      game_over <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state     <= ST_GAP;
            score_bcd <= 16'h0000;
            time_bcd  <= TIME_INIT;
            sec_cnt   <= '0;
            gap_cnt   <= '0;
            up_cnt    <= '0;
            mole      <= 4'd0;
            game_over <= 1'b0;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
          if (gap_done) begin
            state  <= ST_UP;
            mole   <= 4'b0001 << idx_next;
            prev   <= idx_next;
            up_cnt <= '0;
          end
        end
        default: begin
          up_cnt <= up_cnt + UW'(1);
          if (hit_now) begin
            state     <= ST_GAP;
            mole      <= 4'd0;
            hit       <= 1'b1;
            score_bcd <= bcd_inc(score_bcd);
            gap_cnt   <= '0;
          end else if (up_done) begin
            state   <= ST_GAP;
            mole    <= 4'd0;
            miss    <= 1'b1;
            gap_cnt <= '0;
          end
        end
      endcase
      // game clock; its expiry overrides whatever the play states chose
      if (in_play) begin
        sec_cnt <= sec_tick ? '0 : sec_cnt + SW'(1);
        if (sec_tick) time_bcd <= time_next;
        if (final_tick) begin
          state     <= ST_OVER;
          mole      <= 4'd0;
          game_over <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mole_field.sv
// Scoreboarded bench for mole_field: expected hit/miss events are queued as
// stimulus is driven and matched against every hit/miss pulse.
module tb_mole_field;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        shooting = 1'b0;
  logic [3:0]  hit_sensor = 4'd0;
  logic [3:0]  mole;
  logic        hit, miss, game_over;
  logic [15:0] score_bcd;
  logic [7:0]  time_bcd;

  mole_field #(.SEC_CYCLES(20), .GAP_CYCLES(3), .UP_CYCLES(8), .GAME_SECS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .shooting(shooting),
    .hit_sensor(hit_sensor), .mole(mole), .hit(hit), .miss(miss),
    .score_bcd(score_bcd), .time_bcd(time_bcd), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_hit;
    logic [15:0] score;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mole_q = 4'd0;
  logic [3:0] last_mole = 4'd0;
  logic       have_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic push_ev(input logic is_hit, input int sc);
    ev_t e;
    e.is_hit = is_hit;
    e.score  = to_bcd(sc);
    exp_q.push_back(e);
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (mole == 4'd0 && n < 40) begin tick(); n++; end
    chk(tag, {31'd0, mole != 4'd0}, 32'd1);
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (mole != 4'd0 && n < 40) begin tick(); n++; end
    chk(tag, {31'd0, mole == 4'd0}, 32'd1);
  endtask

  // Scoreboard: every hit/miss pulse must match the next queued event.
  always @(negedge clk) begin
    if (hit || miss) begin
      if (exp_q.size() == 0) chk("sb_unexpected", {30'd0, hit, miss}, 32'd0);
      else begin
        ev = exp_q.pop_front();
        chk("sb_kind", {30'd0, hit, miss}, {30'd0, ev.is_hit, !ev.is_hit});
        chk("sb_score", {16'd0, score_bcd}, {16'd0, ev.score});
      end
    end
  end

  // Every pop-up is one-hot and differs from the previous hole.
  always @(negedge clk) begin
    if (mole != 4'd0 && mole_q == 4'd0) begin
      chk("onehot", $countones(mole), 32'd1);
      if (have_last) chk("idx_repeat", {31'd0, mole == last_mole}, 32'd0);
      last_mole = mole;
      have_last = 1'b1;
    end
    mole_q = mole;
  end

  initial begin
    int n;
    logic bad;

    // reset, then idle with start low
    repeat (3) tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      bad |= (mole != 0) || hit || miss || game_over || (score_bcd != 0) || (time_bcd != 8'h03);
    end
    chk("idle_hold", {31'd0, bad}, 32'd0);
    chk("rst_mole", {28'd0, mole}, 32'd0);
    chk("rst_score", {16'd0, score_bcd}, 32'h0000);
    chk("rst_time", {24'd0, time_bcd}, 32'h03);
    chk("rst_over", {31'd0, game_over}, 32'd0);

    // game 1: never fire; five timeouts fit in three seconds
    for (int i = 0; i < 5; i++) push_ev(1'b0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("gap_low", {28'd0, mole}, 32'd0);
    tick();
    chk("mole_up", {31'd0, mole != 0}, 32'd1);
    n = 0;
    while (mole != 0 && n < 20) begin tick(); n++; end
    chk("up_len", n, 32'd8);
    chk("miss_pulse", {31'd0, miss}, 32'd1);
    n = 0;
    while (mole == 0 && n < 20) begin tick(); n++; end
    chk("gap_len", n, 32'd3);
    n = 0;
    while (!game_over && n < 300) begin tick(); n++; end
    chk("over1", {31'd0, game_over}, 32'd1);
    chk("over1_time", {24'd0, time_bcd}, 32'h00);
    chk("over1_score", {16'd0, score_bcd}, 32'h0000);
    chk("over1_mole", {28'd0, mole}, 32'd0);
    chk("over1_drain", exp_q.size(), 32'd0);

    // game 2: hit every mole on its second up-cycle; the 12th hit lands on
    // the final decrement
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_score", {16'd0, score_bcd}, 32'h0000);
    chk("restart_time", {24'd0, time_bcd}, 32'h03);
    chk("restart_over", {31'd0, game_over}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      wait_rise("hit_wait");
      tick();
      if (k == 11) chk("pre_final_time", {24'd0, time_bcd}, 32'h01);
      push_ev(1'b1, k + 1);
      shooting = 1'b1; hit_sensor = mole;
      tick();
      shooting = 1'b0; hit_sensor = 4'd0;
      chk("hit_pulse", {31'd0, hit}, 32'd1);
      chk("hit_mole_off", {28'd0, mole}, 32'd0);
      if (k == 9) chk("bcd_carry", {16'd0, score_bcd}, 32'h0010);
    end
    chk("final_over", {31'd0, game_over}, 32'd1);
    chk("final_time", {24'd0, time_bcd}, 32'h00);
    chk("final_score", {16'd0, score_bcd}, 32'h0012);
    repeat (5) tick();
    chk("held_score", {16'd0, score_bcd}, 32'h0012);
    chk("held_over", {31'd0, game_over}, 32'd1);
    chk("held_mole", {28'd0, mole}, 32'd0);

    // game 3: negative cases, one timeout, one hit, then reset mid-game
    start = 1'b1; tick(); start = 1'b0;
    chk("g3_score", {16'd0, score_bcd}, 32'h0000);
    chk("g3_time", {24'd0, time_bcd}, 32'h03);
    shooting = 1'b1; hit_sensor = 4'hF;
    tick(); tick(); tick();
    chk("neg_gap_hit", {31'd0, hit}, 32'd0);
    chk("neg_mole_up", {31'd0, mole != 0}, 32'd1);
    hit_sensor = ~mole;
    tick();
    chk("neg_other_hole", {31'd0, hit}, 32'd0);
    shooting = 1'b0; hit_sensor = mole;
    tick();
    chk("neg_no_fire", {31'd0, hit}, 32'd0);
    chk("neg_score", {16'd0, score_bcd}, 32'h0000);
    hit_sensor = 4'd0;
    push_ev(1'b0, 0);
    wait_fall("g3_timeout");
    wait_rise("g3_rise2");
    tick();
    push_ev(1'b1, 1);
    shooting = 1'b1; hit_sensor = mole;
    tick();
    shooting = 1'b0; hit_sensor = 4'd0;
    chk("g3_score1", {16'd0, score_bcd}, 32'h0001);
    wait_rise("g3_rise3");
    have_last = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_mole", {28'd0, mole}, 32'd0);
    chk("mid_rst_hit", {31'd0, hit}, 32'd0);
    chk("mid_rst_miss", {31'd0, miss}, 32'd0);
    chk("mid_rst_score", {16'd0, score_bcd}, 32'h0000);
    chk("mid_rst_time", {24'd0, time_bcd}, 32'h03);
    chk("mid_rst_over", {31'd0, game_over}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      bad |= (mole != 0) || hit || miss || (time_bcd != 8'h03);
    end
    chk("mid_rst_idle", {31'd0, bad}, 32'd0);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_field.md
# mole_field

Downstream game-logic stage for the laser whack-a-mole cabinet. It consumes the registered `shooting` flag from the gun stage together with per-hole photo-sensor inputs. It pops up one mole at a time at pseudo-random holes, scores a hit when the gun is firing while the lit mole's sensor sees the beam, and runs a countdown game timer. Score and time leave as packed BCD, ready for the four-digit seven-segment driver.

## Interface
Parameters:
- `SEC_CYCLES`, default 100_000_000: clock cycles per game second.
- `GAP_CYCLES`, default 25_000_000: cycles with all moles down between pop-ups.
- `UP_CYCLES`, default 75_000_000: maximum cycles a mole stays up.
- `GAME_SECS`, default 30: game length in seconds, range 1..99.

Ports:
- `clk` in 1: system clock. One clock domain; everything is registered on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: start/restart request. Level-sampled; acted on only in IDLE or OVER.
- `shooting` in 1: gun-stage fire flag, already synchronous to `clk`.
- `hit_sensor` in 4: photo-sensor per hole, 1 = beam detected. Synchronised outside this block.
- `mole` out 4: one-hot mole LEDs, or all zero.
- `hit` out 1: one-cycle pulse on each scored hit.
- `miss` out 1: one-cycle pulse when a mole times out.
- `score_bcd` out 16: four BCD digits, [15:12] is thousands.
- `time_bcd` out 8: two BCD digits of seconds remaining.
- `game_over` out 1: high in OVER.

## Operation
- States: IDLE, GAP, UP, OVER. On reset the block enters IDLE.
- IDLE:
  - All moles are down.
  - On `start`: `score_bcd` clears to 0, `time_bcd` loads `GAME_SECS`, the second counter clears, and the state moves to GAP.
- GAP:
  - `gap_cnt` counts 0..`GAP_CYCLES-1`.
  - On the terminal count the state moves to UP and `mole[idx]` is set, where `idx` is chosen as below.
- Mole selection:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 advances every cycle, including in IDLE, and is reset to the seed.
  - Candidate index is `lfsr[1:0]`. If it equals the previous index, `idx = prev+1` mod 4, so the same hole never appears twice in a row.
  - `prev` resets to 0.
- UP:
  - `up_cnt` counts 0..`UP_CYCLES-1`.
  - Hit: `shooting & hit_sensor[idx]` in any UP cycle. Next cycle `mole` = 0, `hit` = 1, score +1, state GAP.
  - Firing or sensor activity on any other hole is ignored; so is a sensor without `shooting`.
  - Timeout: terminal `up_cnt` with no hit. Next cycle `mole` = 0, `miss` = 1, state GAP. A hit on the terminal cycle takes priority over the timeout.
- Score arithmetic:
  - BCD increment with a per-digit carry (9 → 0, carry to the next digit).
  - Saturates at 9999.
- Timer:
  - `sec_cnt` runs only in GAP and UP.
  - At `SEC_CYCLES-1` it wraps and `time_bcd` decrements in BCD (x0 → (x-1)9).
  - When the decrement reaches 00, the next state is OVER, overriding any GAP/UP transition.
  - A hit detected in that same cycle is still scored.
- OVER:
  - `mole` = 0 and `game_over` = 1; score and `time_bcd` = 00 are held.
  - On `start`: full restart exactly as from IDLE. The LFSR and `prev` are not reset.
- `start` is ignored while in GAP or UP.

## Timing
- Reset values: `mole` = 0, `hit` = 0, `miss` = 0, `score_bcd` = 16'h0000, `time_bcd` = BCD(`GAME_SECS`), `game_over` = 0, all counters = 0.
- Every output is a register; there are no combinational paths from input to output.
- `start` sampled in cycle t → GAP from t+1; mole rises at t+1+`GAP_CYCLES`.
- Hit condition in cycle t → in cycle t+1: `mole` = 0, `hit` = 1, `score_bcd` updated. GAP starts at t+1 with `gap_cnt` = 0.
- Mole uptime without a hit is exactly `UP_CYCLES` cycles; `miss` coincides with the first cycle the mole is low.
- The first `time_bcd` decrement occurs `SEC_CYCLES` cycles after entry to GAP.
- `rst` mid-game: the next cycle shows reset values; any pending `hit`/`miss` pulse is dropped.

## Test plan
Run with `SEC_CYCLES`=20, `GAP_CYCLES`=3, `UP_CYCLES`=8, `GAME_SECS`=3.
- Reset, hold `start` low for 50 cycles → state stays IDLE; `mole` = 0, `score_bcd` = 0000, `time_bcd` = 03, `game_over` = 0, no pulses.
- Pulse `start`, never fire → the mole rises 3 cycles after GAP entry and stays up 8 cycles. `miss` pulses once, then 3 cycles low. Consecutive mole indices always differ.
- Fire with `hit_sensor` matching the lit mole on its 2nd up-cycle → one-cycle `hit`, `score_bcd` = 0001, mole low the next cycle. Repeat to check BCD carry 0009 → 0010.
- Negative cases → score unchanged and no `hit`:
  - `shooting` = 1 with a non-matching sensor.
  - Matching sensor with `shooting` = 0.
  - Both asserted during GAP.
- Hit in the same cycle as the final decrement, with `time_bcd` going 01 → 00 → `hit` pulses, score +1, `game_over` = 1, moles off, score held. `start` then clears the score to 0000 and sets `time_bcd` to 03.
- Assert `rst` while a mole is up → next cycle all outputs equal their reset values and the state is IDLE.
